// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
// The slice width is fixed at 16 bits to match the shared adder.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of an index able to address `value` slices; never less than 1 bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder_16_bit.sv
// Shared 16-bit ripple datapath: sum and carry-out of a + b + cin.
module full_adder_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one shared 16-bit adder, stepping through
// the operand slices LSB first with the carry held in a register.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int W     = SLICE_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         abort,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int IDX_W = clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef logic [WORDS-1:0][SLICE_W-1:0] wide_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  wide_t            a_q, a_d;
  wide_t            b_q, b_d;
  wide_t            acc_q, acc_d;
  wide_t            result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  full_adder_16_bit u_adder (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;  // subtract as A + ~B + 1
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d[idx_q] = slice_sum;
          carry_d      = slice_cout;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            result_d   = acc_d;
            cout_d     = slice_cout;
            overflow_d = (a_q[WORDS-1][SLICE_W-1] == b_q[WORDS-1][SLICE_W-1]) &&
                         (slice_sum[SLICE_W-1] != a_q[WORDS-1][SLICE_W-1]);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      // NOTE: operand/accumulator registers are reset as well, since result must read 0 straight out of reset.
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (WORDS=4): stimulus pushes expected
// results, a negedge monitor pops and compares whenever done is seen.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         abort;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total;
  int   bad;
  int   done_seen;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .abort    (abort),
    .op_a     (op_a),
    .op_b     (op_b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with result %h, expected no done", result);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.r);
        check("cout", W'(cout), W'(mon_e.c));
        check("overflow", W'(overflow), W'(mon_e.o));
      end
    end
  end

  // Issue one operation from an aligned IDLE cycle and measure start-to-done latency.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic ab, input logic [W-1:0] er, input logic ec, input logic eo);
    int  n;
    bit  got;
    op_a  = a;
    op_b  = b;
    sub   = s;
    abort = ab;
    start = 1'b1;
    check("ready_at_start", W'(ready), W'(1));
    sb_q.push_back('{r: er, c: ec, o: eo});
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    sub   = ~s;
    n     = 0;
    got   = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    check("latency", W'(n), W'(WORDS + 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    total     = 0;
    bad       = 0;
    done_seen = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    sub       = 1'b0;
    abort     = 1'b0;
    op_a      = '0;
    op_b      = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", W'(ready), W'(1));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_overflow", W'(overflow), W'(0));
    @(posedge clk);
    #1;

    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op(64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    // abort together with start in IDLE must not block acceptance
    do_op(64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);

    // Start held every cycle: only the IDLE cycles (k=0 and k=6) are accepted.
    base = done_seen;
    sb_q.push_back('{r: 64'h1111_2222_0000_0000, c: 1'b0, o: 1'b0});
    sb_q.push_back('{r: 64'h1111_2222_0000_0606, c: 1'b0, o: 1'b0});
    for (int k = 0; k < 12; k++) begin
      op_a  = 64'h1111_0000_0000_0000 + 64'(k);
      op_b  = 64'h0000_2222_0000_0000 + 64'(k) * 64'h100;
      sub   = k[0];
      start = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("burst_done_count", W'(done_seen - base), W'(2));

    // Abort in the second RUN cycle: back to IDLE, outputs untouched.
    base  = done_seen;
    op_a  = 64'd1;
    op_b  = 64'd2;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_ready", W'(ready), W'(1));
    check("abort_result", result, 64'h1111_2222_0000_0606);
    check("abort_cout", W'(cout), W'(0));
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", W'(done_seen - base), W'(0));

    // Asynchronous reset mid-RUN.
    base  = done_seen;
    op_a  = 64'd3;
    op_b  = 64'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ready", W'(ready), W'(1));
    check("midrst_result", result, '0);
    check("midrst_done", W'(done), W'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_done", W'(done_seen - base), W'(0));
    check("scoreboard_empty", W'(sb_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
